apb_master_ctrl: RTL and testbench
==================================

# apb_master_ctrl

Single-slave APB initiator that turns a valid/ready command stream into APB transfers and returns a buffered read-data/error response. It drives the profiler register bank, and any other APB register block, from a local sequencer or debug engine in the PCLK domain. Exactly one transfer is outstanding at a time. An optional watchdog aborts transfers that a slave never completes.

## Interface
Parameters:
- ADR_W, 32, APB address width
- DAT_W, 32, APB data width
- TIMEOUT_CYC, 256, number of consecutive ACCESS cycles with PREADY low before abort (used only with the watchdog); legal range 2..65535

Ports:
- PCLK  in  1  sole clock; all logic on posedge
- PRESETn  in  1  reset, synchronous, active-low
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  command accepted when high with CMD_VALID
- CMD_WRITE  in  1  1 = write, 0 = read
- CMD_ADDR  in  ADR_W  target address
- CMD_WDATA  in  DAT_W  write data (ignored on reads)
- RSP_VALID  out  1  response held
- RSP_READY  in  1  response consumed when high with RSP_VALID
- RSP_RDATA  out  DAT_W  read data; 0 for writes and for aborts
- RSP_ERR  out  2  00 OKAY, 01 SLVERR, 10 TIMEOUT, 11 reserved/never driven
- PADDR  out  ADR_W; PSEL  out  1; PENABLE  out  1; PWRITE  out  1; PWDATA  out  DAT_W
- PREADY  in  1; PRDATA  in  DAT_W; PSLVERR  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: CMD_READY = (state==IDLE) & (!RSP_VALID | RSP_READY), combinational. On accept, register addr/write/wdata into PADDR/PWRITE/PWDATA and go to SETUP.
- SETUP: PSEL=1, PENABLE=0. Always advances to ACCESS after one cycle.
- ACCESS: PSEL=1, PENABLE=1. On an edge with PREADY=1:
  - capture PRDATA (reads only, else 0) into RSP_RDATA
  - RSP_ERR = {1'b0, PSLVERR}
  - set RSP_VALID and return to IDLE
- PADDR, PWRITE and PWDATA are stable from SETUP through the completing ACCESS cycle. They hold their last value in IDLE. PWDATA is forced to 0 on reads.
- Response register: RSP_VALID clears on the RSP_READY handshake. It stays asserted while the consumer stalls. Response fields are not modified while RSP_VALID is high.
- Response handshake and new-command accept in the same cycle is legal: the old response drops and a new SETUP begins.
- PSLVERR and PRDATA are sampled only in the completing ACCESS cycle.
- Reset values:
  - state IDLE
  - PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA = 0
  - RSP_VALID = 0, RSP_RDATA = 0, RSP_ERR = 00
  - CMD_READY = 1 (combinational from these values)
- Reset asserted mid-transfer: PSEL/PENABLE deassert at that edge, the transfer is abandoned, and no response is produced.

## Timing
- Command accepted at edge N → SETUP in cycle N+1 → ACCESS in N+2.
- With a zero-wait slave (PREADY=1 in the first ACCESS cycle), RSP_VALID is high in cycle N+3.
- Each PREADY-low cycle in ACCESS adds one cycle.
- With RSP_READY tied high, back-to-back throughput is one transfer per 3 cycles.
- PSEL is never high for more than one cycle without PENABLE. There is no idle gap requirement between transfers.

## Configuration
- APB_MST_TIMEOUT_EN defined:
  - a counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0
  - when it reaches TIMEOUT_CYC-1 with PREADY still 0, the next edge drops PSEL/PENABLE, returns to IDLE, and posts RSP_ERR=10 with RSP_RDATA=0
  - PREADY=1 on the same edge wins over timeout
- Undefined: no counter; ACCESS waits indefinitely; RSP_ERR is never 10.

## Structure
- Shared package apb_mst_pkg holds:
  - the FSM state enum
  - response codes RSP_OKAY=2'b00, RSP_SLVERR=2'b01, RSP_TIMEOUT=2'b10
  - the default TIMEOUT_CYC
- One sub-module, apb_mst_wdt: loadable saturating timeout counter with `clr`, `inc` and `expired` signals. It is instantiated only under APB_MST_TIMEOUT_EN.

## Test plan
- Write 0xDEADBEEF to 0x0000_0010, zero-wait slave → PSEL high N+1..N+2, PENABLE high N+2, PWDATA=0xDEADBEEF, RSP_VALID at N+3 with RSP_ERR=00, RSP_RDATA=0.
- Read 0x0000_0004, slave inserts 3 wait states and returns 0x0000_1234 → PENABLE high 4 cycles, addr stable throughout, RSP_RDATA=0x1234, ERR=00.
- Read with PSLVERR=1 on the completing cycle → RSP_ERR=01; RSP_READY held low for 5 cycles → RSP_VALID and fields stable, CMD_READY=0 throughout.
- Back-to-back 4 writes with RSP_READY=1 → commands accepted every 3 cycles; no SETUP without a following ACCESS.
- PRESETn low during ACCESS of a read → PSEL/PENABLE 0 after that edge, RSP_VALID stays 0, CMD_READY=1 after reset release.
- Timeout: with APB_MST_TIMEOUT_EN and TIMEOUT_CYC=8, slave never asserts PREADY → abort after 8 ACCESS cycles, RSP_ERR=10, RDATA=0. Without the macro, PENABLE remains high for 100+ cycles.

Source files
------------

// File: rtl/apb_mst_pkg.sv
// rtl/apb_mst_pkg.sv - shared FSM state, response codes and defaults for the APB initiator
package apb_mst_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam logic [1:0] RSP_OKAY    = 2'b00;
   localparam logic [1:0] RSP_SLVERR  = 2'b01;
   localparam logic [1:0] RSP_TIMEOUT = 2'b10;

   localparam int TIMEOUT_CYC_DEF = 256;

endpackage

// File: rtl/apb_mst_wdt.sv
// rtl/apb_mst_wdt.sv - saturating ACCESS-phase timeout counter for the APB initiator
// expired is high once LIMIT-1 stalled cycles have been counted since the last clr.
module apb_mst_wdt
   import apb_mst_pkg::*;
#(
   parameter int LIMIT = TIMEOUT_CYC_DEF
) (
   input  logic clk,
   input  logic resetn,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam logic [15:0] LAST = 16'(LIMIT - 1);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = 16'd0;
      end else if (inc && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == LAST);

endmodule

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - single-outstanding APB initiator with buffered response
// Optional ACCESS watchdog enabled by APB_MST_TIMEOUT_EN.
module apb_master_ctrl
   import apb_mst_pkg::*;
#(
   parameter int ADR_W       = 32,
   parameter int DAT_W       = 32,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic             PCLK,
   input  logic             PRESETn,
   input  logic             CMD_VALID,
   output logic             CMD_READY,
   input  logic             CMD_WRITE,
   input  logic [ADR_W-1:0] CMD_ADDR,
   input  logic [DAT_W-1:0] CMD_WDATA,
   output logic             RSP_VALID,
   input  logic             RSP_READY,
   output logic [DAT_W-1:0] RSP_RDATA,
   output logic [1:0]       RSP_ERR,
   output logic [ADR_W-1:0] PADDR,
   output logic             PSEL,
   output logic             PENABLE,
   output logic             PWRITE,
   output logic [DAT_W-1:0] PWDATA,
   input  logic             PREADY,
   input  logic [DAT_W-1:0] PRDATA,
   input  logic             PSLVERR
);

   apb_state_e       state_q, state_d;
   logic [ADR_W-1:0] paddr_q, paddr_d;
   logic             pwrite_q, pwrite_d;
   logic [DAT_W-1:0] pwdata_q, pwdata_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [DAT_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]       rsp_err_q, rsp_err_d;
   logic             timeout;

`ifdef APB_MST_TIMEOUT_EN
   apb_mst_wdt #(
      .LIMIT (TIMEOUT_CYC)
   ) u_wdt (
      .clk     (PCLK),
      .resetn  (PRESETn),
      .clr     (state_q == ST_SETUP),
      .inc     ((state_q == ST_ACCESS) && !PREADY),
      .expired (timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   assign CMD_READY = (state_q == ST_IDLE) && (!rsp_valid_q || RSP_READY);
   assign PSEL      = (state_q != ST_IDLE);
   assign PENABLE   = (state_q == ST_ACCESS);
   assign PADDR     = paddr_q;
   assign PWRITE    = pwrite_q;
   assign PWDATA    = pwdata_q;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_RDATA = rsp_rdata_q;
   assign RSP_ERR   = rsp_err_q;

   always_comb begin
      state_d     = state_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      if (rsp_valid_q && RSP_READY) begin
         rsp_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (CMD_VALID && CMD_READY) begin
               paddr_d  = CMD_ADDR;
               pwrite_d = CMD_WRITE;
               pwdata_d = CMD_WRITE ? CMD_WDATA : '0;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            // A completing PREADY takes priority over a watchdog expiry in the same cycle.
            if (PREADY) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = pwrite_q ? '0 : PRDATA;
               rsp_err_d   = PSLVERR ? RSP_SLVERR : RSP_OKAY;
            end else if (timeout) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_err_d   = RSP_TIMEOUT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q     <= ST_IDLE;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= RSP_OKAY;
      end else begin
         state_q     <= state_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb/tb_apb_master_ctrl.sv - directed and randomized bench for apb_master_ctrl
module tb_apb_master_ctrl;

   logic        PCLK;
   logic        PRESETn;
   logic        CMD_VALID;
   logic        CMD_READY;
   logic        CMD_WRITE;
   logic [31:0] CMD_ADDR;
   logic [31:0] CMD_WDATA;
   logic        RSP_VALID;
   logic        RSP_READY;
   logic [31:0] RSP_RDATA;
   logic [1:0]  RSP_ERR;
   logic [31:0] PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic        PREADY;
   logic [31:0] PRDATA;
   logic        PSLVERR;

   apb_master_ctrl #(
      .ADR_W       (32),
      .DAT_W       (32),
      .TIMEOUT_CYC (8)
   ) dut (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .CMD_VALID (CMD_VALID),
      .CMD_READY (CMD_READY),
      .CMD_WRITE (CMD_WRITE),
      .CMD_ADDR  (CMD_ADDR),
      .CMD_WDATA (CMD_WDATA),
      .RSP_VALID (RSP_VALID),
      .RSP_READY (RSP_READY),
      .RSP_RDATA (RSP_RDATA),
      .RSP_ERR   (RSP_ERR),
      .PADDR     (PADDR),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PWDATA    (PWDATA),
      .PREADY    (PREADY),
      .PRDATA    (PRDATA),
      .PSLVERR   (PSLVERR)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // Slave model: completes after wait_n stalled ACCESS cycles; data/err are garbage otherwise.
   int          wait_n  = 0;
   int          acc_cnt = 0;
   logic        s_err   = 1'b0;
   logic [31:0] s_rdata = 32'h0;

   always @(posedge PCLK) acc_cnt <= (PSEL && PENABLE) ? acc_cnt + 1 : 0;

   assign PREADY  = PSEL && PENABLE && (acc_cnt == wait_n);
   assign PRDATA  = PREADY ? s_rdata : ~s_rdata;
   assign PSLVERR = PREADY ? s_err : ~s_err;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
      cyc++;
   endtask

   task automatic drain();
      RSP_READY = 1'b1;
      tick();
      RSP_READY = 1'b0;
   endtask

   // Offers one command and returns in the SETUP cycle that follows acceptance.
   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input int w, input logic e, input logic [31:0] rd);
      logic ok;
      wait_n    = w;
      s_err     = e;
      s_rdata   = rd;
      CMD_WRITE = wr;
      CMD_ADDR  = a;
      CMD_WDATA = d;
      CMD_VALID = 1'b1;
      ok        = 1'b0;
      for (int k = 0; k < 10 && !ok; k++) begin
         #1;
         ok = CMD_READY;
         tick();
      end
      CMD_VALID = 1'b0;
      chk("issue_accept", ok, 1);
   endtask

   typedef struct {
      int          due;
      logic [31:0] rdata;
      logic [1:0]  err;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   int          pen;
   int          n;
   int          acc_t[4];
   logic        flag;
   logic        prev_setup;
   logic        took;
   logic        in_flight, held, exp_ready, acc, wr;
   int          acc_edge, sent;
   logic [31:0] cur_addr, cur_wdata;
   logic        cur_write;
   localparam int NTX = 250;

   initial begin
      #400000;
      $display("FAIL watchdog: got=hang exp=finish");
      $fatal(1);
   end

   initial begin
      PRESETn   = 1'b0;
      CMD_VALID = 1'b0;
      CMD_WRITE = 1'b0;
      CMD_ADDR  = 32'h0;
      CMD_WDATA = 32'h0;
      RSP_READY = 1'b0;
      repeat (3) tick();

      chk("rst_psel", PSEL, 0);
      chk("rst_penable", PENABLE, 0);
      chk("rst_pwrite", PWRITE, 0);
      chk("rst_paddr", PADDR, 0);
      chk("rst_pwdata", PWDATA, 0);
      chk("rst_rsp_valid", RSP_VALID, 0);
      chk("rst_rsp_rdata", RSP_RDATA, 0);
      chk("rst_rsp_err", RSP_ERR, 0);
      chk("rst_cmd_ready", CMD_READY, 1);
      PRESETn = 1'b1;
      tick();

      // Zero-wait write.
      issue(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'h0);
      chk("wr_setup_psel", PSEL, 1);
      chk("wr_setup_pen", PENABLE, 0);
      chk("wr_pwrite", PWRITE, 1);
      chk("wr_paddr", PADDR, 32'h10);
      chk("wr_pwdata", PWDATA, 32'hDEADBEEF);
      tick();
      chk("wr_access_psel", PSEL, 1);
      chk("wr_access_pen", PENABLE, 1);
      chk("wr_access_pwdata", PWDATA, 32'hDEADBEEF);
      tick();
      chk("wr_done_psel", PSEL, 0);
      chk("wr_rsp_valid", RSP_VALID, 1);
      chk("wr_rsp_err", RSP_ERR, 2'b00);
      chk("wr_rsp_rdata", RSP_RDATA, 0);
      drain();
      chk("wr_rsp_cleared", RSP_VALID, 0);

      // Read with three wait states.
      issue(1'b0, 32'h4, 32'h5555, 3, 1'b0, 32'h1234);
      chk("rd_pwdata_zero", PWDATA, 0);
      pen  = 0;
      flag = 1'b1;
      for (int k = 0; k < 20 && !RSP_VALID; k++) begin
         if (PENABLE) pen++;
         if (PSEL && PADDR !== 32'h4) flag = 1'b0;
         tick();
      end
      chk("rd_pen_cycles", pen, 4);
      chk("rd_addr_stable", flag, 1);
      chk("rd_rsp_valid", RSP_VALID, 1);
      chk("rd_rsp_rdata", RSP_RDATA, 32'h1234);
      chk("rd_rsp_err", RSP_ERR, 2'b00);
      drain();

      // Slave error with a stalled consumer.
      issue(1'b0, 32'h8, 32'h0, 1, 1'b1, 32'hCAFE0001);
      for (int k = 0; k < 20 && !RSP_VALID; k++) tick();
      chk("se_rsp_valid", RSP_VALID, 1);
      chk("se_rsp_err", RSP_ERR, 2'b01);
      chk("se_rsp_rdata", RSP_RDATA, 32'hCAFE0001);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("se_hold_valid", RSP_VALID, 1);
         chk("se_hold_err", RSP_ERR, 2'b01);
         chk("se_hold_rdata", RSP_RDATA, 32'hCAFE0001);
         chk("se_hold_cmd_ready", CMD_READY, 0);
      end
      drain();
      chk("se_cleared", RSP_VALID, 0);

      // Four back-to-back writes with the consumer always ready.
      RSP_READY  = 1'b1;
      wait_n     = 0;
      s_err      = 1'b0;
      CMD_WRITE  = 1'b1;
      CMD_ADDR   = 32'h100;
      CMD_WDATA  = 32'h1000;
      CMD_VALID  = 1'b1;
      n          = 0;
      flag       = 1'b0;
      prev_setup = 1'b0;
      for (int k = 0; k < 40 && n < 4; k++) begin
         if (prev_setup && !PENABLE) flag = 1'b1;
         prev_setup = PSEL && !PENABLE;
         #1;
         took = CMD_READY;
         if (took) begin
            acc_t[n] = cyc;
            n++;
         end
         tick();
         if (took) begin
            CMD_ADDR  = CMD_ADDR + 32'd4;
            CMD_WDATA = CMD_WDATA + 32'd1;
            if (n == 4) CMD_VALID = 1'b0;
         end
      end
      for (int k = 0; k < 6; k++) begin
         if (prev_setup && !PENABLE) flag = 1'b1;
         prev_setup = PSEL && !PENABLE;
         tick();
      end
      chk("b2b_accepts", n, 4);
      for (int i = 0; i < 3; i++) chk("b2b_spacing", acc_t[i+1] - acc_t[i], 3);
      chk("b2b_setup_then_access", flag, 0);
      chk("b2b_drained", RSP_VALID, 0);
      RSP_READY = 1'b0;

      // Reset in the middle of an ACCESS phase.
      issue(1'b0, 32'h20, 32'h0, 5, 1'b0, 32'hAAAA);
      tick();
      chk("rst_mid_in_access", PENABLE, 1);
      PRESETn = 1'b0;
      tick();
      chk("rst_mid_psel", PSEL, 0);
      chk("rst_mid_penable", PENABLE, 0);
      chk("rst_mid_rsp_valid", RSP_VALID, 0);
      PRESETn = 1'b1;
      tick();
      chk("rst_rel_cmd_ready", CMD_READY, 1);
      repeat (8) tick();
      chk("rst_rel_no_rsp", RSP_VALID, 0);

      // Slave that never completes.
      issue(1'b0, 32'h30, 32'h0, 32'h7FFF_FFFF, 1'b0, 32'h77);
`ifdef APB_MST_TIMEOUT_EN
      pen = 0;
      for (int k = 0; k < 40 && !RSP_VALID; k++) begin
         if (PENABLE) pen++;
         tick();
      end
      chk("to_access_cycles", pen, 8);
      chk("to_rsp_valid", RSP_VALID, 1);
      chk("to_rsp_err", RSP_ERR, 2'b10);
      chk("to_rsp_rdata", RSP_RDATA, 0);
      chk("to_psel_dropped", PSEL, 0);
      drain();
`else
      pen = 0;
      for (int k = 0; k < 120; k++) begin
         tick();
         if (PENABLE) pen++;
      end
      chk("hang_penable_cycles", pen, 120);
      chk("hang_no_rsp", RSP_VALID, 0);
      PRESETn = 1'b0;
      tick();
      PRESETn = 1'b1;
      tick();
`endif

      // Randomized traffic against a transaction-level model.
      sent     = 0;
      acc_edge = 0;
      for (int k = 0; k < 6000 && (sent < NTX || exp_q.size() > 0); k++) begin
         in_flight = (exp_q.size() > 0) && (cyc < exp_q[0].due);
         held      = (exp_q.size() > 0) && (cyc >= exp_q[0].due);
         chk("rnd_rsp_valid", RSP_VALID, held);
         chk("rnd_psel", PSEL, in_flight);
         chk("rnd_penable", PENABLE, in_flight && (cyc > acc_edge));
         if (in_flight) begin
            chk("rnd_paddr", PADDR, cur_addr);
            chk("rnd_pwrite", PWRITE, cur_write);
            chk("rnd_pwdata", PWDATA, cur_write ? cur_wdata : 32'h0);
         end
         RSP_READY = ($urandom_range(0, 9) < 7);
         if (!CMD_VALID && !in_flight && sent < NTX && $urandom_range(0, 3) != 0) begin
            wr        = 1'($urandom_range(0, 1));
            CMD_WRITE = wr;
            CMD_ADDR  = $urandom;
            CMD_WDATA = $urandom;
            wait_n    = $urandom_range(0, 4);
            s_err     = ($urandom_range(0, 3) == 0);
            s_rdata   = $urandom;
            CMD_VALID = 1'b1;
         end
         exp_ready = !in_flight && (!held || RSP_READY);
         #1;
         chk("rnd_cmd_ready", CMD_READY, exp_ready);
         if (held && RSP_READY) begin
            chk("rnd_rsp_rdata", RSP_RDATA, exp_q[0].rdata);
            chk("rnd_rsp_err", RSP_ERR, exp_q[0].err);
            void'(exp_q.pop_front());
         end
         acc = CMD_VALID && exp_ready;
         if (acc) begin
            e.due     = cyc + 3 + wait_n;
            e.rdata   = CMD_WRITE ? 32'h0 : s_rdata;
            e.err     = {1'b0, s_err};
            exp_q.push_back(e);
            acc_edge  = cyc + 1;
            cur_addr  = CMD_ADDR;
            cur_write = CMD_WRITE;
            cur_wdata = CMD_WDATA;
            sent++;
         end
         tick();
         if (acc) CMD_VALID = 1'b0;
      end
      chk("rnd_all_sent", sent, NTX);
      chk("rnd_all_consumed", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
